// File: rtl/arduino_pkg.sv
// Shared types and constants for the Arduino note serial link.
// State codes double as the debug code shown on db_estado.
package arduino_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [2:0] FRAME_MARKER         = 3'b101;
    localparam logic [7:0] SILENCE_BYTE         = 8'h00;
    localparam int         DEFAULT_CLKS_PER_BIT = 5208;

    // The marker bits guarantee every real candidate differs from silence.
    function automatic logic [7:0] make_candidate(input logic       sel,
                                                  input logic [3:0] nota_mem,
                                                  input logic [3:0] nota_btn);
        return {FRAME_MARKER, sel, (sel ? nota_mem : nota_btn)};
    endfunction

endpackage

// File: rtl/arduino_baud_gen.sv
// Clearable bit-period counter: tick_o marks the last cycle of a bit,
// pre_tick_o the cycle before it (lets callers register a last-cycle output).
module arduino_baud_gen
    import arduino_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock_i,
    input  logic reset_n_i,
    input  logic clear_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] PRE_CNT  = 16'(CLKS_PER_BIT - 2);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = clear_i ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o     = (cnt_q == LAST_CNT);
    assign pre_tick_o = (cnt_q == PRE_CNT);

endmodule

// File: rtl/arduino_note_tx.sv
// Serial note transmitter to the Arduino: change-detected one-slot queue feeding an 8N1 UART FSM.
// Build with ARDUINO_TX_PARITY_EN defined to add an even-parity bit (11-bit frames).
module arduino_note_tx
    import arduino_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       activateArduino,
    input  logic       sel_memoria_arduino,
    input  logic [3:0] nota_memoria,
    input  logic [3:0] nota_botoes,
    output logic       tx,
    output logic       busy,
    output logic       enviado,
    output logic [2:0] db_estado
);

    state_e     state_q;
    logic       tx_q;
    logic       busy_q;
    logic       enviado_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;

    logic [7:0] pend_q,     pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic [7:0] last_q,     last_d;
    logic       act_q;
    logic [7:0] cand;
    logic       consume;
    logic       tick;
    logic       pre_tick;
    logic       baud_clr;

    // Counter idles at zero so every state entry starts a fresh bit period.
    assign baud_clr = (state_q == ST_IDLE) || tick;

    arduino_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock_i    (clock),
        .reset_n_i  (reset_n),
        .clear_i    (baud_clr),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    assign cand    = make_candidate(sel_memoria_arduino, nota_memoria, nota_botoes);
    assign consume = (state_q == ST_IDLE) && pend_vld_q;

    // A same-cycle event wins over the consume, so it stays queued.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        last_d     = last_q;
        if (consume) begin
            pend_vld_d = 1'b0;
        end
        if (activateArduino && (cand != last_q)) begin
            pend_d     = cand;
            pend_vld_d = 1'b1;
            last_d     = cand;
        end else if (act_q && !activateArduino) begin
            pend_d     = SILENCE_BYTE;
            pend_vld_d = 1'b1;
            last_d     = SILENCE_BYTE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pend_q     <= SILENCE_BYTE;
            pend_vld_q <= 1'b0;
            last_q     <= SILENCE_BYTE;
            act_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            last_q     <= last_d;
            act_q      <= activateArduino;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            enviado_q <= 1'b0;
            shift_q   <= 8'h00;
            bit_q     <= 3'd0;
        end else begin
            enviado_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_vld_q) begin
                        shift_q <= pend_q;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= 3'd0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_q == 3'd7) begin
                            bit_q <= 3'd0;
`ifdef ARDUINO_TX_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= ^shift_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[bit_q + 3'd1];
                        end
                    end
                end
`ifdef ARDUINO_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // Raised one cycle early so the registered pulse lands on the last stop cycle.
                    if (pre_tick) begin
                        enviado_q <= 1'b1;
                    end
                    if (tick) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign enviado   = enviado_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_arduino_note_tx.sv
// Bench for arduino_note_tx: frame-level queue model checked every cycle,
// plus a line monitor decoding bytes and directed literal checks.
module tb_arduino_note_tx;

    localparam int N = 4;
`ifdef ARDUINO_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_LEN = FRAME_BITS * N;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       activateArduino = 1'b0;
    logic       sel_memoria_arduino = 1'b0;
    logic [3:0] nota_memoria = 4'h0;
    logic [3:0] nota_botoes = 4'h0;
    logic       tx;
    logic       busy;
    logic       enviado;
    logic [2:0] db_estado;

    always #5 clock = ~clock;

    arduino_note_tx #(.CLKS_PER_BIT(N)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .activateArduino     (activateArduino),
        .sel_memoria_arduino (sel_memoria_arduino),
        .nota_memoria        (nota_memoria),
        .nota_botoes         (nota_botoes),
        .tx                  (tx),
        .busy                (busy),
        .enviado             (enviado),
        .db_estado           (db_estado)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    typedef struct packed {
        logic       tx;
        logic       busy;
        logic       env;
        logic [2:0] st;
    } obs_t;

    localparam obs_t IDLE_OBS = obs_t'{1'b1, 1'b0, 1'b0, 3'd0};

    obs_t       exp_q[$];
    obs_t       cur = IDLE_OBS;
    bit         model_live = 1'b0;
    logic       m_pv = 1'b0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_last = 8'h00;
    logic       m_act = 1'b0;
    logic [7:0] m_cand;
    logic       m_was_idle;

    task automatic push_frame(input logic [7:0] b);
        for (int i = 0; i < N; i++) exp_q.push_back(obs_t'{1'b0, 1'b1, 1'b0, 3'd1});
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < N; i++) exp_q.push_back(obs_t'{b[k], 1'b1, 1'b0, 3'd2});
`ifdef ARDUINO_TX_PARITY_EN
        for (int i = 0; i < N; i++) exp_q.push_back(obs_t'{^b, 1'b1, 1'b0, 3'd3});
`endif
        for (int i = 0; i < N; i++) exp_q.push_back(obs_t'{1'b1, 1'b1, (i == N - 1), 3'd4});
    endtask

    always @(posedge clock) begin
        m_cand     = {3'b101, sel_memoria_arduino, (sel_memoria_arduino ? nota_memoria : nota_botoes)};
        m_was_idle = !cur.busy;
        if (!reset_n) begin
            exp_q.delete();
            cur        = IDLE_OBS;
            m_pv       = 1'b0;
            m_pend     = 8'h00;
            m_last     = 8'h00;
            m_act      = 1'b0;
            model_live = 1'b1;
        end else begin
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
            end else if (m_was_idle && m_pv) begin
                push_frame(m_pend);
                m_pv = 1'b0;
                cur  = exp_q.pop_front();
            end else begin
                cur = IDLE_OBS;
            end
            if (activateArduino && (m_cand != m_last)) begin
                m_pend = m_cand; m_pv = 1'b1; m_last = m_cand;
            end else if (m_act && !activateArduino) begin
                m_pend = 8'h00; m_pv = 1'b1; m_last = 8'h00;
            end
            m_act = activateArduino;
        end
    end

    always @(negedge clock) begin
        if (model_live)
            check("cycle{tx,busy,env,state}", {26'd0, tx, busy, enviado, db_estado}, {26'd0, cur});
    end

    // ---------------- line monitor ----------------
    logic [7:0] rx_q[$];
    int         env_q[$];
    logic [7:0] rx_sh = 8'h00;
    logic       busy_prev = 1'b0;
    int         fr_cnt = 0, fr_env = 0, gap = 0, last_gap = 0;
    int         env_total = 0, busy_total = 0;

    always @(negedge clock) begin
        if (busy === 1'b1) begin
            if (!busy_prev) begin
                last_gap = gap; fr_cnt = 0; fr_env = 0;
            end else begin
                fr_cnt++;
            end
            gap = 0;
            busy_total++;
            if (fr_cnt >= N && fr_cnt < 9 * N && (fr_cnt % N) == N / 2)
                rx_sh[fr_cnt / N - 1] = tx;
            if (enviado === 1'b1) fr_env++;
            if (fr_cnt == FRAME_LEN - 1) begin
                rx_q.push_back(rx_sh);
                env_q.push_back(fr_env);
            end
        end else begin
            gap++;
        end
        if (enviado === 1'b1) env_total++;
        busy_prev = (busy === 1'b1);
    end

    task automatic wait_rx(input int target, input int budget);
        int c = 0;
        while (rx_q.size() < target && c < budget) begin
            @(negedge clock);
            c++;
        end
        check("frame_arrival", rx_q.size(), target);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ebase;
        int bbase;

        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_enviado", enviado, 0);
        check("rst_state", db_estado, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // First note: latency and byte content
        activateArduino = 1'b1; sel_memoria_arduino = 1'b1; nota_memoria = 4'h3;
        @(negedge clock);
        check("lat_edge1_tx", tx, 1);
        @(negedge clock);
        check("lat_edge2_tx", tx, 0);
        check("lat_edge2_busy", busy, 1);
        wait_rx(1, 100);
        repeat (3) @(negedge clock);
        check("byte_B3", rx_q[0], 8'hB3);
        check("enviado_per_frame", env_q[0], 1);
        check("busy_cycles_frame", busy_total, FRAME_LEN);

        // Constant inputs: nothing further
        base = rx_q.size(); bbase = busy_total;
        repeat (200) @(negedge clock);
        check("hold_busy_cycles", busy_total - bbase, 0);
        check("hold_frames", rx_q.size(), base);

        // Mid-frame changes: latest wins
        base = rx_q.size();
        nota_memoria = 4'h4;
        repeat (12) @(negedge clock);
        sel_memoria_arduino = 1'b0; nota_botoes = 4'h5;
        repeat (8) @(negedge clock);
        nota_botoes = 4'h6;
        wait_rx(base + 2, 200);
        check("byte_B4", rx_q[base], 8'hB4);
        check("byte_A6", rx_q[base + 1], 8'hA6);
        check("gap_after_B4", last_gap, 1);
        repeat (100) @(negedge clock);
        check("no_A5_frame", rx_q.size(), base + 2);

        // Deactivate while idle: silence frame
        base = rx_q.size();
        activateArduino = 1'b0;
        wait_rx(base + 1, 150);
        check("byte_silence", rx_q[base], 8'h00);
        repeat (5) @(negedge clock);

        // Reset during data bit 4, then the same input is resent
        base = rx_q.size(); ebase = env_total;
        activateArduino = 1'b1; sel_memoria_arduino = 1'b1; nota_memoria = 4'h3;
        repeat (23) @(negedge clock);
        check("pre_abort_state", db_estado, 2);
        reset_n = 1'b0;
        @(negedge clock);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        @(negedge clock);
        reset_n = 1'b1;
        check("abort_no_enviado", env_total - ebase, 0);
        wait_rx(base + 1, 150);
        check("resent_B3", rx_q[base], 8'hB3);
        check("resent_enviado", env_total - ebase, 1);
        repeat (5) @(negedge clock);

        // Event on the final stop cycle
        base = rx_q.size();
        nota_memoria = 4'h7;
        repeat (FRAME_LEN + 1) @(negedge clock);
        check("final_stop_enviado", enviado, 1);
        check("final_stop_state", db_estado, 4);
        sel_memoria_arduino = 1'b0; nota_botoes = 4'h9;
        @(negedge clock);
        check("one_idle_busy", busy, 0);
        @(negedge clock);
        check("restart_tx", tx, 0);
        check("restart_busy", busy, 1);
        wait_rx(base + 2, 150);
        check("byte_B7", rx_q[base], 8'hB7);
        check("byte_A9", rx_q[base + 1], 8'hA9);
        check("gap_after_B7", last_gap, 1);
        repeat (5) @(negedge clock);

        // Event in the same cycle the idle FSM takes the pending byte
        base = rx_q.size();
        nota_botoes = 4'hC;
        @(negedge clock);
        nota_botoes = 4'hD;
        wait_rx(base + 2, 300);
        check("byte_AC", rx_q[base], 8'hAC);
        check("byte_AD", rx_q[base + 1], 8'hAD);
        check("gap_after_AC", last_gap, 1);
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arduino_note_tx.md
ARDUINO_NOTE_TX -- requirements
Module: arduino_note_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have ports: clock  in  1  system clock; all logic on its rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset; synchronous to clock, active-low.
REQ-004 SHALL have ports: activateArduino  in  1  link enable from control unit.
REQ-005 SHALL have ports: sel_memoria_arduino  in  1  1 = memory note selected, 0 = button note selected.
REQ-006 SHALL have ports: nota_memoria  in  4  note code read from sequence memory.
REQ-007 SHALL have ports: nota_botoes  in  4  note code from encoded buttons.
REQ-008 SHALL have ports: tx  out  1  serial line to Arduino, idle high.
REQ-009 SHALL have ports: busy  out  1  high while a frame is on tx.
REQ-010 SHALL have ports: enviado  out  1  one-cycle pulse at the end of each stop bit.
REQ-011 SHALL have ports: db_estado  out  3  current FSM state code, for debug.

Function
REQ-012 SHALL form candidate byte = {3'b101, sel_memoria_arduino, selected note}; the selected note is nota_memoria when sel=1, else nota_botoes.
REQ-013 SHALL, on an edge with activateArduino=1 and candidate != last_queued, load pending <= candidate, pending_valid <= 1, last_queued <= candidate.
REQ-014 SHALL, on an edge where activateArduino goes 1->0, load pending <= 8'h00 (silence), pending_valid <= 1, last_queued <= 8'h00.
REQ-015 SHALL hold one pending slot; a newer event overwrites an unsent pending byte (latest wins), and no frame is ever queued twice.
REQ-016 SHALL run FSM states IDLE(0), START(1), DATA(2), PARITY(3, macro only), STOP(4).
REQ-017 SHALL hold each state for exactly CLKS_PER_BIT cycles, timed by a baud counter that is cleared on every state entry.
REQ-018 IDLE: tx=1, busy=0; when pending_valid=1, copy pending to shift register, clear pending_valid, go to START.
REQ-019 START drives tx=0. DATA drives 8 bits LSB first, bit index 0..7, then goes to the next state with the index wrapped to 0. STOP drives tx=1.
REQ-020 SHALL assert enviado on the final cycle of STOP, then go to IDLE; if pending_valid=1 at that point, START SHALL follow after exactly one IDLE cycle.
REQ-021 Latency: start bit SHALL appear on tx 2 edges after the input change when the FSM is IDLE.
REQ-022 An event arriving in the same cycle IDLE consumes pending SHALL survive in pending; the in-flight shift register SHALL NOT be altered.
REQ-023 busy SHALL be 1 in every state except IDLE.

Reset
REQ-024 With reset_n=0 at an edge: state=IDLE, tx=1, busy=0, enviado=0, db_estado=0, pending_valid=0, pending=8'h00, last_queued=8'h00, baud and bit counters=0, activate history=0.
REQ-025 Reset mid-frame SHALL abort the frame; tx is 1 from the first edge with reset_n=0, and no partial stop or enviado pulse is produced.
REQ-026 After reset, the first enabled sample with nonzero candidate SHALL be sent, since every candidate has upper bits 101 and therefore differs from 8'h00.

Configuration
REQ-027 Macro ARDUINO_TX_PARITY_EN defined: after DATA, the PARITY state SHALL drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame length is 11 bits.
REQ-028 Macro ARDUINO_TX_PARITY_EN undefined: DATA SHALL go directly to STOP, code 3 is never produced, and frame length is 10 bits.

Structure
REQ-029 Package arduino_pkg SHALL hold the state encodings, the frame marker 3'b101, the silence byte 8'h00, and the default CLKS_PER_BIT.
REQ-030 Sub-module arduino_baud_gen SHALL hold the clearable baud counter and output the last-cycle-of-bit tick; the FSM, pending slot and change detector stay in arduino_note_tx.

Verification (CLKS_PER_BIT=4)
REQ-031 Reset then activate=1, sel=1, nota_memoria=4'h3 -> tx low 2 edges later; byte 8'hB3 sent LSB first; 40 cycles per frame (44 with parity); enviado pulses once.
REQ-032 Hold inputs constant for 200 cycles after the frame -> no further frame, busy stays 0.
REQ-033 Mid-frame change to sel=0, nota_botoes=4'h5, then 4'h6 before frame end -> only 8'hA6 follows, after one IDLE cycle.
REQ-034 activate 1->0 while IDLE -> frame 8'h00 is sent; with parity enabled the parity bit is 0.
REQ-035 reset_n=0 during DATA bit 4 -> tx=1 next edge, busy=0, no enviado; after release, the same input is resent in full.
REQ-036 Event coinciding with the final STOP cycle -> enviado pulse, one IDLE cycle, then the new frame starts.
